bvh_update_seq: RTL and testbench

BVH_UPDATE_SEQ -- requirements
Module: bvh_update_seq

---
 rtl/bvh_pkg.sv | 18 +
 rtl/bvh_range_chunker.sv | 21 ++
 rtl/bvh_update_seq.sv | 141 ++++++++++++++
 tb/tb_bvh_update_seq.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bvh_pkg.sv
// Shared encodings for the BVH update sequencer.
// Opcodes, FSM state codes and the default refit batch size.
package bvh_pkg;

  localparam int CHUNK_DEF = 64;

  localparam logic [1:0] OP_MORTON = 2'd0;
  localparam logic [1:0] OP_SORT   = 2'd1;
  localparam logic [1:0] OP_EMIT   = 2'd2;
  localparam logic [1:0] OP_REFIT  = 2'd3;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_ADVANCE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

endpackage

// File: rtl/bvh_range_chunker.sv
// Slices [cursor, total) into refit batches of at most CHUNK prims.
// last marks the batch that reaches total.
module bvh_range_chunker import bvh_pkg::*; #(
  parameter int PRIM_W = 16,
  parameter int CHUNK  = CHUNK_DEF
) (
  input  logic [PRIM_W-1:0] total,
  input  logic [PRIM_W-1:0] cursor,
  output logic [PRIM_W-1:0] len,
  output logic              last
);

  localparam logic [PRIM_W-1:0] CH = PRIM_W'(CHUNK);

  logic [PRIM_W-1:0] rem;

  assign rem  = (cursor >= total) ? '0 : total - cursor;
  assign last = (rem <= CH);
  assign len  = last ? rem : CH;

endmodule

// File: rtl/bvh_update_seq.sv
// Sequences BVH rebuild (MORTON/SORT/EMIT) and chunked refit jobs
// onto a single-outstanding kernel command port.
module bvh_update_seq import bvh_pkg::*; #(
  parameter int PRIM_W = 16,
  parameter int CHUNK  = CHUNK_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_rebuild,
  input  logic              start_refit,
  input  logic [PRIM_W-1:0] prim_count,
  output logic              kern_valid,
  input  logic              kern_ready,
  output logic [1:0]        kern_op,
  output logic [PRIM_W-1:0] kern_base,
  output logic [PRIM_W-1:0] kern_len,
  input  logic              kern_done,
  output logic              job_done,
  output logic              job_was_rebuild,
  output logic              busy,
  output logic              err_stray_done
);

  logic [2:0]        state;
  logic              rebuild_pend;
  logic              refit_pend;
  logic              is_rebuild;
  logic [1:0]        phase;
  logic [PRIM_W-1:0] total;
  logic [PRIM_W-1:0] cursor;
  logic [PRIM_W-1:0] chunk_len;
  logic              chunk_last;
  logic              take_rb;
  logic              take_rf;
  logic              clr_rf;

  bvh_range_chunker #(
    .PRIM_W (PRIM_W),
    .CHUNK  (CHUNK)
  ) u_chunker (
    .total  (total),
    .cursor (cursor),
    .len    (chunk_len),
    .last   (chunk_last)
  );

  assign take_rb = (state == S_IDLE) && rebuild_pend;
  assign take_rf = (state == S_IDLE) && !rebuild_pend && refit_pend;
  // a finished rebuild also retires any refit queued behind it
  assign clr_rf  = take_rf || ((state == S_DONE) && is_rebuild);
  assign busy    = (state != S_IDLE) || rebuild_pend || refit_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rebuild_pend <= 1'b0;
      refit_pend   <= 1'b0;
    end else begin
      rebuild_pend <= (rebuild_pend && !take_rb) || start_rebuild;
      refit_pend   <= (refit_pend && !clr_rf) ||
                      (start_refit && !start_rebuild);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      is_rebuild      <= 1'b0;
      phase           <= 2'd0;
      total           <= '0;
      cursor          <= '0;
      kern_valid      <= 1'b0;
      kern_op         <= 2'd0;
      kern_base       <= '0;
      kern_len        <= '0;
      job_done        <= 1'b0;
      job_was_rebuild <= 1'b0;
      err_stray_done  <= 1'b0;
    end else begin
      job_done <= 1'b0;
      if (kern_done && state != S_WAIT)
        err_stray_done <= 1'b1;
      case (state)
        S_IDLE: begin
          if (take_rb || take_rf) begin
            is_rebuild <= take_rb;
            total      <= prim_count;
            cursor     <= '0;
            phase      <= 2'd0;
            if (prim_count == '0) begin
              state           <= S_DONE;
              job_done        <= 1'b1;
              job_was_rebuild <= take_rb;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (!kern_valid) begin
            kern_valid <= 1'b1;
            kern_op    <= is_rebuild ? phase : OP_REFIT;
            kern_base  <= is_rebuild ? '0 : cursor;
            kern_len   <= is_rebuild ? total : chunk_len;
          end else if (kern_ready) begin
            kern_valid <= 1'b0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (kern_done)
            state <= S_ADVANCE;
        end
        S_ADVANCE: begin
          if (is_rebuild) begin
            if (phase == OP_EMIT) begin
              state           <= S_DONE;
              job_done        <= 1'b1;
              job_was_rebuild <= 1'b1;
            end else begin
              phase <= phase + 2'd1;
              state <= S_ISSUE;
            end
          end else begin
            cursor <= chunk_last ? total : cursor + chunk_len;
            // a pending rebuild preempts the remaining refit chunks
            if (chunk_last || rebuild_pend) begin
              state           <= S_DONE;
              job_done        <= 1'b1;
              job_was_rebuild <= 1'b0;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bvh_update_seq.sv
// Directed scoreboard bench for bvh_update_seq.
// A small kernel model records commands and job_done events in order.
module tb_bvh_update_seq;

  typedef struct packed {
    logic        job;
    logic [1:0]  op;
    logic [15:0] base;
    logic [15:0] len;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_rebuild;
  logic        start_refit;
  logic [15:0] prim_count;
  logic        kern_valid;
  logic        kern_ready;
  logic [1:0]  kern_op;
  logic [15:0] kern_base;
  logic [15:0] kern_len;
  logic        kern_done;
  logic        job_done;
  logic        job_was_rebuild;
  logic        busy;
  logic        err_stray_done;

  int n_total = 0;
  int n_bad   = 0;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  first_valid;
  int  hold_cyc;
  int  unstable;

  always #5 clk = ~clk;

  bvh_update_seq #(.PRIM_W(16), .CHUNK(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .start_rebuild   (start_rebuild),
    .start_refit     (start_refit),
    .prim_count      (prim_count),
    .kern_valid      (kern_valid),
    .kern_ready      (kern_ready),
    .kern_op         (kern_op),
    .kern_base       (kern_base),
    .kern_len        (kern_len),
    .kern_done       (kern_done),
    .job_done        (job_done),
    .job_was_rebuild (job_was_rebuild),
    .busy            (busy),
    .err_stray_done  (err_stray_done)
  );

  function automatic ev_t cmd(logic [1:0] op, int b, int l);
    return ev_t'{1'b0, op, 16'(b), 16'(l)};
  endfunction

  function automatic ev_t job(logic rb);
    return ev_t'{1'b1, {1'b0, rb}, 16'd0, 16'd0};
  endfunction

  // Kernel model: serves commands, pulses kern_done two cycles after
  // acceptance and logs every command and job_done in arrival order.
  task automatic run_kernel(input int want_jobs, input int stall,
                            input int inj_at);
    int   dcnt = 0;
    int   ncmd = 0;
    int   jobs = 0;
    int   st = stall;
    ev_t  held;
    logic have_held = 1'b0;
    obs_q.delete();
    first_valid = -1;
    hold_cyc = 0;
    unstable = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      start_rebuild = 1'b0;
      start_refit = 1'b0;
      kern_done = 1'b0;
      if (job_done) begin
        obs_q.push_back(job(job_was_rebuild));
        jobs++;
      end
      if (jobs >= want_jobs && !busy) break;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) kern_done = 1'b1;
      end
      if (kern_valid && first_valid < 0) first_valid = c;
      kern_ready = (st == 0);
      if (kern_valid && !kern_ready) begin
        if (!have_held) begin
          held = cmd(kern_op, kern_base, kern_len);
          have_held = 1'b1;
        end else if (held !== cmd(kern_op, kern_base, kern_len)) begin
          unstable++;
        end
        hold_cyc++;
        st--;
      end else if (kern_valid && kern_ready) begin
        obs_q.push_back(cmd(kern_op, kern_base, kern_len));
        dcnt = 2;
        ncmd++;
        if (ncmd == inj_at) start_rebuild = 1'b1;
      end
    end
    kern_ready = 1'b0;
    kern_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_rebuild = 1'b0;
    start_refit = 1'b0;
    prim_count = '0;
    kern_ready = 1'b0;
    kern_done = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({kern_valid, kern_op, kern_base, kern_len, job_done,
         job_was_rebuild, busy, err_stray_done} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got v=%b op=%0d b=%0d l=%0d jd=%b rb=%b busy=%b err=%b want all 0",
               kern_valid, kern_op, kern_base, kern_len, job_done,
               job_was_rebuild, busy, err_stray_done);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_refit();
    exp_q.delete();
    exp_q.push_back(cmd(2'd3, 0, 64));
    exp_q.push_back(cmd(2'd3, 64, 64));
    exp_q.push_back(cmd(2'd3, 128, 22));
    exp_q.push_back(job(1'b0));
    prim_count = 16'd150;
    start_refit = 1'b1;
    run_kernel(1, 0, 0);
    n_total++;
    if (first_valid !== 2) begin
      n_bad++;
      $display("FAIL refit_latency got=%0d want=2", first_valid);
    end
    n_total++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL refit_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ev_t e = exp_q.pop_front();
      ev_t o = obs_q.pop_front();
      n_total++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL refit_ev got=%h want=%h", o, e);
      end
    end
  endtask

  task automatic test_rebuild_stall();
    exp_q.delete();
    for (int p = 0; p < 3; p++) exp_q.push_back(cmd(2'(p), 0, 1000));
    exp_q.push_back(job(1'b1));
    prim_count = 16'd1000;
    start_rebuild = 1'b1;
    run_kernel(1, 5, 0);
    n_total++;
    if (hold_cyc !== 5 || unstable !== 0) begin
      n_bad++;
      $display("FAIL stall_hold got hold=%0d unstable=%0d want hold=5 unstable=0",
               hold_cyc, unstable);
    end
    n_total++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL rebuild_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ev_t e = exp_q.pop_front();
      ev_t o = obs_q.pop_front();
      n_total++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL rebuild_ev got=%h want=%h", o, e);
      end
    end
  endtask

  task automatic test_preempt();
    exp_q.delete();
    exp_q.push_back(cmd(2'd3, 0, 64));
    exp_q.push_back(cmd(2'd3, 64, 64));
    exp_q.push_back(job(1'b0));
    for (int p = 0; p < 3; p++) exp_q.push_back(cmd(2'(p), 0, 300));
    exp_q.push_back(job(1'b1));
    prim_count = 16'd300;
    start_refit = 1'b1;
    run_kernel(2, 0, 2);
    n_total++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL preempt_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ev_t e = exp_q.pop_front();
      ev_t o = obs_q.pop_front();
      n_total++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL preempt_ev got=%h want=%h", o, e);
      end
    end
  endtask

  task automatic test_simultaneous();
    exp_q.delete();
    for (int p = 0; p < 3; p++) exp_q.push_back(cmd(2'(p), 0, 5));
    exp_q.push_back(job(1'b1));
    prim_count = 16'd5;
    start_rebuild = 1'b1;
    start_refit = 1'b1;
    run_kernel(1, 0, 0);
    n_total++;
    if (dut.refit_pend !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL simul_pend got refit_pend=%b busy=%b want 0 0",
               dut.refit_pend, busy);
    end
    n_total++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL simul_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ev_t e = exp_q.pop_front();
      ev_t o = obs_q.pop_front();
      n_total++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL simul_ev got=%h want=%h", o, e);
      end
    end
  endtask

  task automatic test_zero();
    @(negedge clk);
    prim_count = 16'd0;
    start_refit = 1'b1;
    @(negedge clk);
    start_refit = 1'b0;
    n_total++;
    if (job_done !== 1'b0 || kern_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_c1 got jd=%b v=%b want 0 0", job_done, kern_valid);
    end
    @(negedge clk);
    n_total++;
    if (job_done !== 1'b1 || job_was_rebuild !== 1'b0 || kern_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_c2 got jd=%b rb=%b v=%b want 1 0 0",
               job_done, job_was_rebuild, kern_valid);
    end
    @(negedge clk);
    n_total++;
    if (job_done !== 1'b0 || busy !== 1'b0 || kern_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_after got jd=%b busy=%b v=%b want 0 0 0",
               job_done, busy, kern_valid);
    end
  endtask

  task automatic test_stray();
    @(negedge clk);
    n_total++;
    if (err_stray_done !== 1'b0) begin
      n_bad++;
      $display("FAIL stray_pre got=%b want=0", err_stray_done);
    end
    kern_done = 1'b1;
    @(negedge clk);
    kern_done = 1'b0;
    repeat (4) @(negedge clk);
    n_total++;
    if (err_stray_done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL stray_sticky got err=%b busy=%b want 1 0",
               err_stray_done, busy);
    end
  endtask

  task automatic test_reset_wait();
    int seen = 0;
    int jd = 0;
    prim_count = 16'd100;
    start_rebuild = 1'b1;
    kern_ready = 1'b1;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      start_rebuild = 1'b0;
      if (kern_valid) seen = 1;
    end
    @(negedge clk);
    kern_ready = 1'b0;
    n_total++;
    if (seen == 0) begin
      n_bad++;
      $display("FAIL rstwait_issue got=no kern_valid want=kern_valid within 20 cycles");
    end
    rst = 1'b1;
    #1;
    n_total++;
    if ({kern_valid, kern_op, kern_base, kern_len, job_done,
         job_was_rebuild, busy, err_stray_done} !== '0) begin
      n_bad++;
      $display("FAIL rstwait_outputs got v=%b op=%0d b=%0d l=%0d jd=%b rb=%b busy=%b err=%b want all 0",
               kern_valid, kern_op, kern_base, kern_len, job_done,
               job_was_rebuild, busy, err_stray_done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (job_done || busy || kern_valid) jd++;
    end
    n_total++;
    if (jd !== 0) begin
      n_bad++;
      $display("FAIL rstwait_quiet got=%0d active cycles want=0", jd);
    end
  endtask

  initial begin
    test_reset();
    test_refit();
    test_rebuild_stall();
    test_preempt();
    test_simultaneous();
    test_zero();
    test_stray();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
